// File: rtl/ram8_sweep.sv
// ram8_sweep: 8 x WIDTH register bank with a combinational 8-way read mux,
// synchronous writes, and a one-entry-per-cycle bulk-clear engine.
//
// Handshake: there is no valid/ready pair. `load` and `clear` are sampled on
// every rising edge. A load is accepted only while busy=0. While busy=1 the
// bank ignores both load and clear. In IDLE, a clear wins over a load at the
// same edge. clr_done is a one-cycle pulse that appears as busy falls.
module ram8_sweep #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             clr_done,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage, sweep counter and FSM. All state lives in this one block so a
  // reset mid-sweep aborts everything at once and no done pulse is produced.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (clear) begin
            // Clear has priority; a simultaneous write is dropped.
            r_state <= S_SWEEP;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b1;
          end else if (load) begin
            r_mem[address] <= in;
          end
        end
        S_SWEEP: begin
          // Loads and clears are ignored here: no writes, no restart.
          r_mem[r_cnt] <= '0;
          r_cnt        <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (load) begin
            r_mem[address] <= in;
          end
          if (clear) begin
            r_state <= S_SWEEP;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency read mux plus straight-from-flop status outputs.
  always_comb begin
    out         = r_mem[address];
    busy        = r_busy;
    clr_done    = r_done;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_ram8_sweep.sv
// Bench for ram8_sweep: a table of write vectors followed by hand-written
// sequences that cover the clear sweep and its corner cases.
`timescale 1ns/1ps
module tb_ram8_sweep;

  localparam int W = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic         clock;
  logic         reset_n;
  logic [W-1:0] din;
  logic         load;
  logic [2:0]   address;
  logic         clear;
  logic [W-1:0] dout;
  logic         busy;
  logic         clr_done;
  logic [1:0]   dbg_state;

  ram8_sweep #(.WIDTH(W), .DEPTH(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in          (din),
    .load        (load),
    .address     (address),
    .clear       (clear),
    .out         (dout),
    .busy        (busy),
    .clr_done    (clr_done),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] m [8];

  typedef struct {
    logic [2:0]   addr;
    logic [W-1:0] data;
    logic [W-1:0] exp_before;
    logic [W-1:0] exp_after;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic rd(input string nm, input logic [2:0] a);
    logic [W-1:0] e;
    exp_q.push_back(m[a]);
    address = a;
    #1;
    e = exp_q.pop_front();
    chk(nm, {16'd0, dout}, {16'd0, e});
  endtask

  task automatic rd_all(input string nm);
    for (int i = 0; i < 8; i++) rd(nm, 3'(i));
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    address = a;
    din     = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
    m[a]    = d;
  endtask

  task automatic wr_all();
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h0100 + 16'(i));
  endtask

  int busy_cnt;
  int done_cnt;
  int g;

  initial begin
    din = '0; load = 1'b0; address = '0; clear = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = '0;
    for (int i = 0; i < 8; i++) begin
      vecs[i].addr       = 3'(i);
      vecs[i].data       = 16'h0100 + 16'(i);
      vecs[i].exp_before = 16'h0000;
      vecs[i].exp_after  = 16'h0100 + 16'(i);
    end

    // Reset: 20 ns low, then release
    reset_n = 1'b0;
    #20;
    reset_n = 1'b1;
    #1;
    rd_all("reset_out");
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, clr_done}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    step();

    // Table-driven writes: value visible only after its write edge
    for (int i = 0; i < 8; i++) begin
      address = vecs[i].addr;
      din     = vecs[i].data;
      load    = 1'b1;
      #1;
      chk("wr_before", {16'd0, dout}, {16'd0, vecs[i].exp_before});
      step();
      load = 1'b0;
      chk("wr_after", {16'd0, dout}, {16'd0, vecs[i].exp_after});
      m[vecs[i].addr] = vecs[i].data;
    end
    rd_all("readback");

    // One-cycle clear pulse: sweep progress, busy length, done pulse
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("sweep_busy_start", {31'd0, busy}, 32'd1);
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (busy) busy_cnt++;
      m[k] = '0;
      rd("sweep_cleared", 3'(k));
      if (k < 7) begin
        rd("sweep_untouched", 3'(k + 1));
        chk("sweep_done_low", {31'd0, clr_done}, 32'd0);
      end else begin
        chk("sweep_busy_end", {31'd0, busy}, 32'd0);
        chk("sweep_done_pulse", {31'd0, clr_done}, 32'd1);
      end
    end
    chk("sweep_busy_cycles", busy_cnt, 8);
    step();
    chk("done_one_cycle", {31'd0, clr_done}, 32'd0);
    chk("back_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rd_all("after_sweep");

    // Load and clear during SWEEP are ignored
    wr_all();
    clear = 1'b1;
    step();
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    load = 1'b1; address = 3'd7; din = 16'hBEEF; clear = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
    end
    load = 1'b0; clear = 1'b0;
    g = 0;
    while (busy && g < 20) begin
      step();
      g++;
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
    end
    chk("sweep2_timeout", {31'd0, (g < 20)}, 32'd1);
    for (int j = 0; j < 2; j++) begin
      step();
      if (clr_done) done_cnt++;
    end
    chk("sweep2_busy_cycles", busy_cnt, 8);
    chk("sweep2_done_count", done_cnt, 1);
    for (int i = 0; i < 8; i++) m[i] = '0;
    rd("sweep2_reg7", 3'd7);
    rd_all("sweep2_all");

    // Clear + load together in IDLE: clear wins; write in DONE accepted
    wr(3'd3, 16'h0AAA);
    clear = 1'b1; load = 1'b1; address = 3'd3; din = 16'h1234;
    step();
    clear = 1'b0; load = 1'b0;
    chk("cl_busy", {31'd0, busy}, 32'd1);
    rd("cl_write_dropped", 3'd3);
    g = 0;
    while (!clr_done && g < 20) begin
      step();
      g++;
    end
    chk("cl_done_timeout", {31'd0, (g < 20)}, 32'd1);
    for (int i = 0; i < 8; i++) m[i] = '0;
    load = 1'b1; address = 3'd3; din = 16'h5678;
    step();
    load = 1'b0;
    m[3] = 16'h5678;
    rd("done_write", 3'd3);
    chk("done_write_busy", {31'd0, busy}, 32'd0);
    chk("done_write_pulse", {31'd0, clr_done}, 32'd0);
    chk("done_write_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // Reset mid-sweep: abort, all zero, no done pulse, loads work after
    wr_all();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      m[k] = '0;
    end
    rd("pre_rst_reg5", 3'd5);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, clr_done}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    for (int i = 0; i < 8; i++) m[i] = '0;
    rd_all("rst_regs");
    step();
    reset_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (clr_done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_busy", busy_cnt, 0);
    wr(3'd2, 16'h4242);
    rd("post_rst_write", 3'd2);
    rd("post_rst_other", 3'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram8_sweep.md
Name: ram8_sweep

Overview:
- 8-entry x 16-bit register bank in the nand2tetris memory style.
- Synchronous write. Combinational read: the addressed register is selected by an 8-way 16-bit multiplexer.
- Adds a sequenced bulk-clear engine that zeroes all entries, one per cycle, and reports busy and done.
- Sits directly downstream of the CPU data/address path and feeds the 8-way mux read stage. It is the building block for RAM64 and larger memories.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers; fixed at 8 (address width 3). Other values are not supported.

Ports:
- clock  input  1  single system clock; rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  write data.
- load  input  1  write enable, sampled on the rising clock edge.
- address  input  3  register select for both write and read.
- clear  input  1  bulk-clear request, sampled on the rising clock edge.
- out  output  WIDTH  combinational read data, equal to reg[address].
- busy  output  1  high while the clear sweep is in progress.
- clr_done  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (reset_n=0, asynchronous, independent of clock):
  - all 8 registers = 0; FSM = IDLE; sweep counter = 0; busy = 0; clr_done = 0.
  - out therefore reads 0 for any address.
  - Reset asserted mid-sweep aborts the sweep immediately and returns to IDLE; no done pulse is produced.
- Read: out = reg[address] with zero latency. out follows address changes within the same cycle.
- Write: on a rising edge with load=1 and busy=0, reg[address] <= in.
  - The new value appears on out after that edge (no write-through in the same cycle).
  - load while busy=1 is dropped silently; the register contents are unchanged.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - clear=1 at an edge -> SWEEP, counter <= 0, busy <= 1.
  - clear and load both high at the same edge: clear wins and the write is dropped.
- SWEEP:
  - each edge sets reg[counter] <= 0, then counter <= counter+1.
  - The edge that clears reg[7] -> DONE, busy <= 0, clr_done <= 1, counter wraps to 0.
  - busy is high for exactly 8 cycles.
  - clear in SWEEP is ignored (no restart, no queuing).
- DONE:
  - lasts exactly one cycle; clr_done=1 and busy=0.
  - load is accepted in DONE.
  - clear=1 in DONE starts a new sweep (-> SWEEP); otherwise -> IDLE.
  - clr_done returns to 0 on the next edge.
- Reads during SWEEP return current contents: entries below counter are already 0, the rest are unchanged.
- Counter is 3 bits and wraps 7 -> 0. No address outside 0..7 is possible.
- Registered outputs: busy and clr_done come directly from flops or FSM decode, so they are glitch-free.

Test Plan:
- Reset with reset_n=0 for 20ns, then release -> out=0000 for addresses 0..7; busy=0; clr_done=0.
- Write in=addr+16'h0100 at addresses 0..7 (one per cycle), then sweep address 0..7 -> out=0100,0101,...,0107; each value visible only after its write edge.
- After writing all 8 registers, pulse clear for 1 cycle:
  - busy=1 for exactly 8 cycles, and reg[k] reads 0 after sweep edge k+1;
  - clr_done=1 for one cycle as busy falls;
  - all addresses then read 0000.
- During SWEEP, load=1, address=7, in=BEEF, and clear re-asserted -> write dropped and the sweep is not restarted; reg7 ends 0000; total busy stays 8 cycles.
- Simultaneous clear=1 and load=1 (address=3, in=1234) in IDLE -> write dropped, sweep starts. A write of 5678 to address 3 during DONE is accepted and reads 5678 afterwards.
- reset_n pulsed low at sweep cycle 4 (with reg5..7 holding 0105..0107) -> busy=0 immediately, all registers 0000, no clr_done pulse, FSM in IDLE; a subsequent load works normally.
